// File: rtl/ace_snoop_data_collect.sv
// ace_snoop_data_collect
//   Collects snoop data for one request at a time. The request mask names the
//   masters that will return a line on their CD channel. Every masked master is
//   drained, and the line from the lowest-indexed one is forwarded on a
//   valid/ready output stage. Lines from other sharers are accepted and dropped.
//   An optional timeout aborts collection when masters fail to respond.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request valid            req_ready : accepted when idle
//   req_mask   : per-master "will send data" mask
//   cd_valid   : per-master CD valid      cd_ready  : per-master CD ready
//   cd_data    : master i at [i*DATA_SIZE +: DATA_SIZE]
//   out_valid  : response valid           out_ready : downstream accept
//   out_data   : selected line            out_src   : selected master index
//   out_hit    : out_data holds real data out_err   : collection timed out
module ace_snoop_data_collect #(
    parameter int DATA_SIZE      = 128,
    parameter int NUM_MASTERS    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [NUM_MASTERS-1:0]           req_mask,
    input  logic [NUM_MASTERS-1:0]           cd_valid,
    input  logic [NUM_MASTERS*DATA_SIZE-1:0] cd_data,
    output logic [NUM_MASTERS-1:0]           cd_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_SIZE-1:0]             out_data,
    output logic [$clog2(NUM_MASTERS)-1:0]   out_src,
    output logic                             out_hit,
    output logic                             out_err
);

    localparam int SEL_W = $clog2(NUM_MASTERS);
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                                                    $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESP
    } state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] pending_q;
    logic [SEL_W-1:0]       chosen_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic                   hit_q;
    logic                   err_q;
    logic [TO_W-1:0]        cnt_q;

    logic [NUM_MASTERS-1:0] hs;
    logic [NUM_MASTERS-1:0] pending_d;
    logic                   chosen_hs;
    logic [DATA_SIZE-1:0]   chosen_beat;
    logic                   to_expire;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_MASTERS-1:0] m);
        logic [SEL_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (m[i] && !found) begin
                idx   = SEL_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign cd_ready  = pending_q & {NUM_MASTERS{state_q == COLLECT}};
    assign out_data  = data_q;
    // The selected index doubles as out_src; both load together on accept.
    assign out_src   = chosen_q;
    assign out_hit   = hit_q;
    assign out_err   = err_q;

    always_comb begin
        hs          = cd_valid & cd_ready;
        pending_d   = pending_q & ~hs;
        chosen_hs   = hs[chosen_q];
        chosen_beat = cd_data[int'(chosen_q)*DATA_SIZE +: DATA_SIZE];
        to_expire   = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            chosen_q  <= '0;
            data_q    <= '0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pending_q <= req_mask;
                        chosen_q  <= lowest_idx(req_mask);
                        data_q    <= '0;
                        hit_q     <= 1'b0;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= (req_mask != '0) ? COLLECT : RESP;
                    end
                end
                COLLECT: begin
                    pending_q <= pending_d;
                    // A beat from the chosen master in the timeout cycle still counts.
                    if (chosen_hs) begin
                        data_q <= chosen_beat;
                        hit_q  <= 1'b1;
                    end
                    if (pending_d == '0) begin
                        state_q <= RESP;
                    end else if (to_expire) begin
                        err_q     <= 1'b1;
                        pending_q <= '0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ace_snoop_data_collect.sv
module tb_ace_snoop_data_collect;

    localparam int DW = 128;
    localparam int NM = 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [NM-1:0] req_mask;
    logic [NM-1:0] cd_valid;
    logic [NM*DW-1:0] cd_data;
    logic [NM-1:0] cd_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_src;
    logic          out_hit;
    logic          out_err;

    logic [DW-1:0] cd_word [NM];

    always_comb begin
        cd_data = '0;
        for (int i = 0; i < NM; i++) cd_data[i*DW +: DW] = cd_word[i];
    end

    ace_snoop_data_collect #(
        .DATA_SIZE(DW),
        .NUM_MASTERS(NM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mask(req_mask),
        .cd_valid(cd_valid),
        .cd_data(cd_data),
        .cd_ready(cd_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_src(out_src),
        .out_hit(out_hit),
        .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle
    logic          chk_en = 1'b0;
    logic          e_rr, e_ov, e_hit, e_err;
    logic [NM-1:0] e_cdr;
    logic [DW-1:0] e_data;
    logic [2:0]    e_src;

    // Register contents the model remembers between transactions
    logic [DW-1:0] m_data;
    logic [2:0]    m_src;
    logic          m_hit, m_err;

    // Per-transaction schedule: master i sends its beat in collect cycle sched[i]
    int            sched [NM];
    logic [DW-1:0] cdat  [NM];

    logic          ov_hist [64];
    logic [DW-1:0] cap_data;
    logic [2:0]    cap_src;
    logic          cap_hit, cap_err;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", DW'(req_ready), DW'(e_rr));
            chk("out_valid", DW'(out_valid), DW'(e_ov));
            chk("cd_ready",  DW'(cd_ready),  DW'(e_cdr));
            chk("out_data",  out_data,       e_data);
            chk("out_src",   DW'(out_src),   DW'(e_src));
            chk("out_hit",   DW'(out_hit),   DW'(e_hit));
            chk("out_err",   DW'(out_err),   DW'(e_err));
        end
    end

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_idle_exp();
        e_rr = 1'b1; e_ov = 1'b0; e_cdr = '0;
        e_data = m_data; e_src = m_src; e_hit = m_hit; e_err = m_err;
    endtask

    task automatic cd_noise();
        for (int i = 0; i < NM; i++) begin
            cd_valid[i] = 1'($urandom_range(0, 1));
            cd_word[i]  = rnd128();
        end
    endtask

    task automatic do_txn(input logic [NM-1:0] mask, input int gap, input int hold);
        int            fin;
        logic          tmo, hit;
        logic [2:0]    ch;
        logic [NM-1:0] low;
        logic [DW-1:0] line;
        low = mask & (~mask + 8'd1);
        ch  = (mask == '0) ? 3'd0 : 3'($countones(low - 8'd1));
        fin = 0;
        for (int i = 0; i < NM; i++) if (mask[i] && sched[i] > fin) fin = sched[i];
        tmo = (fin > TO);
        if (tmo) fin = TO;
        hit  = (mask != '0) && (sched[ch] <= fin);
        line = hit ? cdat[ch] : '0;
        for (int i = 0; i < 64; i++) ov_hist[i] = 1'b0;

        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_mask = NM'($urandom); out_ready = 1'($urandom);
            cd_noise();
            set_idle_exp();
            @(negedge clk);
        end

        @(posedge clk); #1;
        req_valid = 1'b1; req_mask = mask; out_ready = 1'($urandom);
        cd_noise();
        set_idle_exp();
        @(negedge clk); #1;
        ov_hist[0] = out_valid;

        for (int k = 1; k <= fin; k++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom); req_mask = NM'($urandom); out_ready = 1'($urandom);
            for (int i = 0; i < NM; i++) begin
                if (mask[i] && sched[i] == k) begin
                    cd_valid[i] = 1'b1; cd_word[i] = cdat[i];
                end else if (mask[i] && sched[i] > k) begin
                    cd_valid[i] = 1'b0; cd_word[i] = rnd128();
                end else begin
                    cd_valid[i] = 1'($urandom_range(0, 1)); cd_word[i] = rnd128();
                end
                e_cdr[i] = mask[i] && (sched[i] >= k);
            end
            e_rr = 1'b0; e_ov = 1'b0; e_src = ch; e_err = 1'b0;
            e_hit  = (sched[ch] < k);
            e_data = e_hit ? cdat[ch] : '0;
            @(negedge clk); #1;
            ov_hist[k] = out_valid;
        end

        m_data = line; m_src = ch; m_hit = hit; m_err = tmo;
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom); req_mask = NM'($urandom); out_ready = (h == hold);
            cd_noise();
            e_rr = 1'b0; e_ov = 1'b1; e_cdr = '0;
            e_data = m_data; e_src = m_src; e_hit = m_hit; e_err = m_err;
            @(negedge clk); #1;
            ov_hist[fin + 1 + h] = out_valid;
            if (h == 0) begin
                cap_data = out_data; cap_src = out_src; cap_hit = out_hit; cap_err = out_err;
            end
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < NM; i++) begin
            sched[i] = 99;
            cdat[i]  = rnd128();
        end
    endtask

    initial begin
        logic [DW-1:0] lit;
        rst = 1'b1; req_valid = 1'b0; req_mask = '0; cd_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < NM; i++) cd_word[i] = '0;
        m_data = '0; m_src = '0; m_hit = 1'b0; m_err = 1'b0;
        set_idle_exp();
        @(posedge clk); @(posedge clk); #1;
        chk_en = 1'b1;              // reset state checked while rst is still high
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of COLLECT, with beats in flight
        @(posedge clk); #1;
        req_valid = 1'b1; req_mask = 8'h0C; cd_valid = '0; set_idle_exp();
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1; cd_valid = 8'h0C;
        e_rr = 1'b0; e_ov = 1'b0; e_cdr = 8'h0C; e_data = '0; e_src = 3'd2; e_hit = 1'b0; e_err = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; cd_valid = '0;
        m_data = '0; m_src = '0; m_hit = 1'b0; m_err = 1'b0;
        set_idle_exp();
        @(negedge clk); #1;
        chk("rst_cd_ready",  DW'(cd_ready),  '0);
        chk("rst_req_ready", DW'(req_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), '0);

        // Single responder
        clear_sched();
        lit = {16{8'hA5}};
        sched[4] = 2; cdat[4] = lit;
        do_txn(8'h10, 1, 0);
        chk("single_ov_early", DW'(ov_hist[2]), '0);
        chk("single_ov",       DW'(ov_hist[3]), DW'(1));
        chk("single_data",     cap_data, lit);
        chk("single_src",      DW'(cap_src), DW'(4));
        chk("single_hit",      DW'(cap_hit), DW'(1));
        chk("single_err",      DW'(cap_err), '0);

        // Multi-hot, skewed beats
        clear_sched();
        lit = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        sched[7] = 1; sched[1] = 3; sched[2] = 5; cdat[1] = lit;
        do_txn(8'h86, 0, 1);
        chk("multi_ov_early", DW'(ov_hist[5]), '0);
        chk("multi_ov",       DW'(ov_hist[6]), DW'(1));
        chk("multi_src",      DW'(cap_src), DW'(1));
        chk("multi_data",     cap_data, lit);

        // Zero mask with back-pressure
        clear_sched();
        do_txn(8'h00, 2, 4);
        chk("zero_ov",   DW'(ov_hist[1]), DW'(1));
        chk("zero_hit",  DW'(cap_hit), '0);
        chk("zero_data", cap_data, '0);
        chk("zero_hold", DW'(ov_hist[5]), DW'(1));

        // Timeout, chosen master silent
        clear_sched();
        sched[1] = 1;
        do_txn(8'h03, 0, 0);
        chk("to0_ov_early", DW'(ov_hist[8]), '0);
        chk("to0_ov",       DW'(ov_hist[9]), DW'(1));
        chk("to0_err",      DW'(cap_err), DW'(1));
        chk("to0_hit",      DW'(cap_hit), '0);
        chk("to0_data",     cap_data, '0);

        // Timeout, chosen master delivered
        clear_sched();
        lit = {4{32'hC0DE_F00D}};
        sched[0] = 3; cdat[0] = lit;
        do_txn(8'h03, 1, 2);
        chk("to1_err",  DW'(cap_err), DW'(1));
        chk("to1_hit",  DW'(cap_hit), DW'(1));
        chk("to1_data", cap_data, lit);
        chk("to1_src",  DW'(cap_src), '0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [NM-1:0] m;
            clear_sched();
            case ($urandom_range(0, 7))
                0:       m = '0;
                1, 2:    m = NM'(1) << $urandom_range(0, NM - 1);
                default: m = NM'($urandom);
            endcase
            for (int i = 0; i < NM; i++)
                sched[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 12) : $urandom_range(1, 5);
            do_txn(m, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(posedge clk); #1;
        req_valid = 1'b0; set_idle_exp();
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
